uart_cmd_rx: RTL and testbench

Host-to-logic-analyzer command receiver for the ice40 demo designs. It samples the RS232 receive line and recovers 8N1 bytes. Each pair of bytes (address, then data) becomes a single-cycle register write strobe to the analyzer's configuration registers, such as trigger pattern, mask and clock qualifier select. It is the inbound counterpart to the analyzer's UART capture-dump transmitter and runs in the PLL clock domain.

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_rx_core.sv | 137 +++++++++++++
 rtl/uart_cmd_rx.sv | 123 ++++++++++++
 tb/tb_uart_cmd_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command receiver.
//   rx_state_e     : byte receiver states (IDLE, START, DATA, STOP)
//   parser_state_e : command parser states (WAIT_ADDR, WAIT_DATA)
//   CMD_MARKER_BIT : bit that marks a byte as a command header
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    typedef enum logic {
        WAIT_ADDR = 1'b0,
        WAIT_DATA = 1'b1
    } parser_state_e;

    localparam int CMD_MARKER_BIT = 7;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver: two-flop synchronizer, bit-period counter and receiver FSM.
//   clk, rst   : clock and synchronous active-high reset
//   rx         : asynchronous serial line, idle high
//   byte_valid : one-cycle pulse for each correctly framed byte
//   rx_byte    : last correctly framed byte, held between frames
//   frame_err  : one-cycle pulse when a stop bit is sampled low
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // Half a bit period lands the start-bit check mid-bit; full periods follow.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q,       sync_d;
    rx_state_e        state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [7:0]       shift_q,      shift_d;
    logic [7:0]       rx_byte_q,    rx_byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q,  frame_err_d;

    logic rx_s;
    logic cnt_zero;

    assign rx_s     = sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        // NOTE: every _d is given its hold value before the case, so no path
        // leaves it unassigned and no latch is inferred.
        sync_d       = {sync_q[0], rx};
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end

            START: begin
                if (cnt_zero) begin
                    if (rx_s) begin
                        // Line came back high by mid-bit: a glitch, not a start.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DATA: begin
                if (cnt_zero) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            STOP: begin
                if (cnt_zero) begin
                    // Back to IDLE immediately so a start bit that follows the
                    // stop bit with no idle gap is still caught.
                    state_d = IDLE;
                    if (rx_s) begin
                        rx_byte_d    = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop take its pre-edge
        // value; blocking ones would collapse the synchronizer into one stage.
        if (rst) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = rx_byte_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: turns (header, data) byte pairs into register writes.
// A header byte has CMD_MARKER_BIT set and carries the 7-bit address; the next
// good byte is the data. A framing error or a long gap abandons the command.
//   clk, rst   : clock and synchronous active-high reset
//   rx         : asynchronous serial line, idle high
//   wr_en      : one-cycle write strobe
//   wr_addr    : write address, held until the next write
//   wr_data    : write data, held until the next write
//   byte_valid : one-cycle pulse per correctly framed byte
//   rx_byte    : last correctly framed byte, held
//   frame_err  : one-cycle pulse on a low stop bit
//   timeout    : one-cycle pulse when a half-received command is abandoned
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 417,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       timeout
);

    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W          = $clog2(TIMEOUT_CYCLES + 1);
    // The parser sees byte_valid one cycle after it rises and timeout is
    // registered, so the count stops two short to place the timeout pulse
    // exactly TIMEOUT_CYCLES after the header's byte_valid.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 2);

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    parser_state_e                 pstate_q,    pstate_d;
    logic [CMD_MARKER_BIT-1:0]     pend_addr_q, pend_addr_d;
    logic [GAP_W-1:0]              gap_q,       gap_d;
    logic                          wr_en_q,     wr_en_d;
    logic [6:0]                    wr_addr_q,   wr_addr_d;
    logic [7:0]                    wr_data_q,   wr_data_d;
    logic                          timeout_q,   timeout_d;

    always_comb begin
        pstate_d    = pstate_q;
        pend_addr_d = pend_addr_q;
        gap_d       = gap_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        timeout_d   = 1'b0;

        case (pstate_q)
            WAIT_ADDR: begin
                // Held at zero here so the timer starts clean on entry.
                gap_d = '0;
                if (byte_valid && rx_byte[CMD_MARKER_BIT]) begin
                    pend_addr_d = rx_byte[CMD_MARKER_BIT-1:0];
                    pstate_d    = WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                // A byte arriving on the terminal-count cycle still wins.
                if (byte_valid) begin
                    wr_addr_d = pend_addr_q;
                    wr_data_d = rx_byte;
                    wr_en_d   = 1'b1;
                    gap_d     = '0;
                    pstate_d  = WAIT_ADDR;
                end else if (frame_err) begin
                    pstate_d  = WAIT_ADDR;
                end else if (gap_q == GAP_LAST) begin
                    timeout_d = 1'b1;
                    pstate_d  = WAIT_ADDR;
                end else begin
                    gap_d     = gap_q + 1'b1;
                end
            end

            default: pstate_d = WAIT_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q    <= WAIT_ADDR;
            pend_addr_q <= '0;
            gap_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            pstate_q    <= pstate_d;
            pend_addr_q <= pend_addr_d;
            gap_q       <= gap_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: a table of two-byte commands plus hand-written
// sequences for glitches, framing errors, the gap timeout and mid-frame reset.
module tb_uart_cmd_rx;

    localparam int CPB = 4;
    // A back-to-back frame is 10 bit times, so the gap limit must exceed that;
    // 16 bit times at 4 clocks per bit gives a 64-cycle abort.
    localparam int TOB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       timeout;

    uart_cmd_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled 1 time unit after each rising edge.
    int bv_cnt = 0, fe_cnt = 0, to_cnt = 0, wr_cnt = 0, overlap_cnt = 0;
    int bv_cyc = 0, wr_cyc = 0, to_cyc = 0;
    always @(posedge clk) begin
        #1;
        if (byte_valid) begin bv_cnt++; bv_cyc = cyc; end
        if (frame_err)  fe_cnt++;
        if (timeout)    begin to_cnt++; to_cyc = cyc; end
        if (wr_en)      begin wr_cnt++; wr_cyc = cyc; end
        if ((int'(byte_valid) + int'(frame_err) + int'(timeout) + int'(wr_en)) > 1)
            overlap_cnt++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 frame starting at a falling clock edge. If rst_bit names a
    // frame bit (0 = start), rst is pulsed for the first two cycles of that bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int rst_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = frame[k];
            for (int c = 0; c < CPB; c++) begin
                if (k == rst_bit) rst = (c < 2);
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic       exp_wr;
        logic [6:0] exp_addr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    int         wr0, bv0, fe0, to0;
    logic [6:0] m_addr;
    logic [7:0] m_data;

    initial begin
        vecs[0] = '{8'h85, 8'h3C, 1'b1, 7'h05, 8'h3C};
        vecs[1] = '{8'h12, 8'h34, 1'b0, 7'h00, 8'h00};
        vecs[2] = '{8'hC0, 8'h80, 1'b1, 7'h40, 8'h80};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 7'h7F, 8'h00};
        vecs[4] = '{8'hAA, 8'hFF, 1'b1, 7'h2A, 8'hFF};
        m_addr = '0;
        m_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst wr_en",      wr_en,      0);
        check("rst wr_addr",    wr_addr,    0);
        check("rst wr_data",    wr_data,    0);
        check("rst byte_valid", byte_valid, 0);
        check("rst rx_byte",    rx_byte,    0);
        check("rst frame_err",  frame_err,  0);
        check("rst timeout",    timeout,    0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle bv count", bv_cnt, 0);

        // Two-byte commands sent back-to-back
        for (int i = 0; i < 5; i++) begin
            wr0 = wr_cnt;
            bv0 = bv_cnt;
            send_byte(vecs[i].b0, 1'b1, -1);
            send_byte(vecs[i].b1, 1'b1, -1);
            repeat (6) @(negedge clk);
            if (vecs[i].exp_wr) begin
                m_addr = vecs[i].exp_addr;
                m_data = vecs[i].exp_data;
                check($sformatf("vec%0d wr lag", i), wr_cyc - bv_cyc, 1);
            end
            check($sformatf("vec%0d wr count", i), wr_cnt - wr0, 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d bv count", i), bv_cnt - bv0, 2);
            check($sformatf("vec%0d rx_byte", i),  rx_byte, vecs[i].b1);
            check($sformatf("vec%0d wr_addr", i),  wr_addr, m_addr);
            check($sformatf("vec%0d wr_data", i),  wr_data, m_data);
        end
        check("no timeout in commands", to_cnt, 0);

        // One-cycle glitch, then a stray byte before a command
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        wr0 = wr_cnt;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch bv", bv_cnt - bv0, 0);
        check("glitch fe", fe_cnt - fe0, 0);
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h81, 1'b1, -1);
        send_byte(8'hFF, 1'b1, -1);
        repeat (6) @(negedge clk);
        check("stray wr count", wr_cnt - wr0, 1);
        check("stray bv count", bv_cnt - bv0, 3);
        check("stray wr_addr",  wr_addr, 7'h01);
        check("stray wr_data",  wr_data, 8'hFF);

        // Header, then a frame with its stop bit low
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        wr0 = wr_cnt;
        send_byte(8'h80, 1'b1, -1);
        send_byte(8'h11, 1'b0, -1);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("ferr fe count", fe_cnt - fe0, 1);
        check("ferr bv count", bv_cnt - bv0, 1);
        check("ferr wr count", wr_cnt - wr0, 0);
        check("ferr rx_byte",  rx_byte, 8'h80);
        send_byte(8'h82, 1'b1, -1);
        send_byte(8'h07, 1'b1, -1);
        repeat (6) @(negedge clk);
        check("after ferr wr count", wr_cnt - wr0, 1);
        check("after ferr wr_addr",  wr_addr, 7'h02);
        check("after ferr wr_data",  wr_data, 8'h07);

        // Header followed by silence: gap timeout
        wr0 = wr_cnt;
        to0 = to_cnt;
        send_byte(8'h90, 1'b1, -1);
        repeat (80) @(negedge clk);
        check("timeout count", to_cnt - to0, 1);
        check("timeout delay", to_cyc - bv_cyc, 64);
        check("timeout wr count", wr_cnt - wr0, 0);
        send_byte(8'h55, 1'b1, -1);
        repeat (80) @(negedge clk);
        check("post-timeout 0x55 wr", wr_cnt - wr0, 0);
        check("post-timeout 0x55 to", to_cnt - to0, 1);
        check("post-timeout rx_byte", rx_byte, 8'h55);

        // Reset during the data bits of the data byte
        wr0 = wr_cnt;
        bv0 = bv_cnt;
        send_byte(8'hA3, 1'b1, -1);
        send_byte(8'hF0, 1'b1, 6);
        repeat (10) @(negedge clk);
        check("mid rst wr count", wr_cnt - wr0, 0);
        check("mid rst bv count", bv_cnt - bv0, 1);
        check("mid rst wr_addr",  wr_addr, 0);
        check("mid rst wr_data",  wr_data, 0);
        check("mid rst rx_byte",  rx_byte, 0);
        send_byte(8'h84, 1'b1, -1);
        send_byte(8'h5A, 1'b1, -1);
        repeat (6) @(negedge clk);
        check("post rst wr count", wr_cnt - wr0, 1);
        check("post rst wr_addr",  wr_addr, 7'h04);
        check("post rst wr_data",  wr_data, 8'h5A);

        check("output overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
